// File: rtl/conv_pkg.sv
// Shared constants for the 3x3x3 conv datapath: window bus layout used by the
// window generator, the PE array moving-operand bus and the drain collector.
package conv_pkg;

  localparam int unsigned CH_NUM    = 3;
  localparam int unsigned K_SIZE    = 3;
  localparam int unsigned WIN_BYTES = 27;
  localparam int unsigned WIN_W     = WIN_BYTES * 8;
  localparam int unsigned PIX_BUS_W = 24;

  localparam int unsigned R_OFS = 144;
  localparam int unsigned G_OFS = 72;
  localparam int unsigned B_OFS = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  // Channel index follows the pixel bus order: 0 = B (LSB), 1 = G, 2 = R.
  function automatic int unsigned ch_ofs(input int unsigned ch);
    case (ch)
      0:       return B_OFS;
      1:       return G_OFS;
      default: return R_OFS;
    endcase
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Single-port line buffer: asynchronous read and synchronous write at the same
// address, intended to map onto distributed RAM.
module conv_line_buf #(
  parameter int unsigned DEPTH  = 416,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 48
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// Raster RGB stream to 3x3x3 window generator feeding the conv PE row.
// Define CONV_WIN_POS_EN to add win_row_o/win_col_o (window centre position).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 416,
  parameter int unsigned IMG_H = 416,
  parameter int unsigned PIX_W = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pix_valid_i,
  output logic                         pix_ready_o,
  input  logic                         pix_sof_i,
  input  logic [PIX_BUS_W-1:0]         pix_data_i,
  output logic                         win_valid_o,
  input  logic                         win_ready_i,
  output logic [WIN_W-1:0]             win_data_o,
`ifdef CONV_WIN_POS_EN
  output logic [$clog2(IMG_H)-1:0]     win_row_o,
  output logic [$clog2(IMG_W)-1:0]     win_col_o,
`endif
  output logic                         frame_done_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_win [K_SIZE][K_SIZE];
  logic          r_win_valid;
  logic [WIN_W-1:0] r_win_data;
  logic          r_win_last;
`ifdef CONV_WIN_POS_EN
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;
`endif

  logic          w_accept;
  logic          w_emit;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  pix_t          w_lb0;
  pix_t          w_lb1;
  pix_t          w_win [K_SIZE][K_SIZE];
  logic [WIN_W-1:0] w_pack;

  assign pix_ready_o  = ~rst_i & (~r_win_valid | win_ready_i);
  assign w_accept     = pix_valid_i & pix_ready_o;
  // SOF relocates the current pixel to (0,0) before it is used anywhere.
  assign w_col        = pix_sof_i ? '0 : r_col;
  assign w_row        = pix_sof_i ? '0 : r_row;
  assign w_emit       = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));

  assign win_valid_o  = r_win_valid;
  assign win_data_o   = r_win_data;
  assign frame_done_o = r_win_valid & win_ready_i & r_win_last;
`ifdef CONV_WIN_POS_EN
  assign win_row_o    = r_win_row;
  assign win_col_o    = r_win_col;
`endif

  conv_line_buf #(
    .DEPTH  (IMG_W),
    .ADDR_W (CW),
    .DATA_W (2 * PIX_BUS_W)
  ) u_line_buf (
    .i_clk   (clk_i),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata ({w_lb0, pix_data_i}),
    .o_rdata ({w_lb1, w_lb0})
  );

  for (genvar gr = 0; gr < K_SIZE; gr++) begin : g_row
    assign w_win[gr][0] = r_win[gr][1];
    assign w_win[gr][1] = r_win[gr][2];
  end
  assign w_win[0][2] = w_lb1;
  assign w_win[1][2] = w_lb0;
  assign w_win[2][2] = pix_data_i;

  // k = row*3+col; k_0 lands at the MSB byte of each channel slice.
  for (genvar gr = 0; gr < K_SIZE; gr++) begin : g_pr
    for (genvar gc = 0; gc < K_SIZE; gc++) begin : g_pc
      for (genvar gch = 0; gch < CH_NUM; gch++) begin : g_pch
        assign w_pack[ch_ofs(gch) + (K_SIZE*K_SIZE - 1 - (gr*K_SIZE + gc))*PIX_W +: PIX_W]
          = w_win[gr][gc][gch*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win       <= '{default: '0};
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_win_last  <= 1'b0;
`ifdef CONV_WIN_POS_EN
      r_win_row   <= '0;
      r_win_col   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_win <= w_win;
        if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_pack;
        r_win_last  <= (w_row == ROW_LAST) && (w_col == COL_LAST);
`ifdef CONV_WIN_POS_EN
        r_win_row   <= w_row - RW'(1);
        r_win_col   <= w_col - CW'(1);
`endif
      end else if (win_ready_i) begin
        r_win_valid <= 1'b0;
      end
    end
  end

endmodule
